// File: rtl/marlann_qpi_phy_pkg.sv
// marlann_qpi_phy_pkg: shared constants for the QPI slave PHY and its users.
// Holds the PHY state encodings, the command opcodes seen by the decoder,
// and a small majority-vote helper for the optional qpi_clk deglitch filter.
package marlann_qpi_phy_pkg;

  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX      = 2'd1;
  localparam logic [1:0] TURN    = 2'd2;
  localparam logic [1:0] TX      = 2'd3;

  localparam logic [7:0] CMD_STATUS    = 8'h20;
  localparam logic [7:0] CMD_WRITE_BUF = 8'h21;
  localparam logic [7:0] CMD_READ_BUF  = 8'h22;
  localparam logic [7:0] CMD_STORE     = 8'h23;
  localparam logic [7:0] CMD_LOAD      = 8'h24;
  localparam logic [7:0] CMD_RUN       = 8'h25;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/marlann_qpi_phy_if.sv
// marlann_qpi_phy_if: pad-side QPI signals plus the byte stream exchanged
// with the command decoder. The PHY uses the slave view; the host pads and
// decoder side (or a bench) use the master view.
interface marlann_qpi_phy_if;
  logic       qpi_csb;
  logic       qpi_clk;
  logic [3:0] qpi_io_in;
  logic [3:0] qpi_io_out;
  logic       qpi_io_oe;
  logic       rx_start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_stop;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport slave (
    input  qpi_csb, qpi_clk, qpi_io_in, tx_en, tx_data, tx_valid,
    output qpi_io_out, qpi_io_oe, rx_start, rx_valid, rx_data, rx_stop, tx_ready
  );

  modport master (
    output qpi_csb, qpi_clk, qpi_io_in, tx_en, tx_data, tx_valid,
    input  qpi_io_out, qpi_io_oe, rx_start, rx_valid, rx_data, rx_stop, tx_ready
  );
endinterface

// File: rtl/marlann_qpi_phy_sync.sv
// marlann_qpi_phy_sync: STAGES-deep synchroniser with rise/fall detection.
// With FILTER set, the synchronised level is a majority vote over the last
// three samples, which swallows single-cycle pulses at the cost of one clock.
module marlann_qpi_phy_sync
  import marlann_qpi_phy_pkg::*;
#(
  parameter int STAGES = 2,
  parameter bit FILTER = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              filt;

  // Shift the async input in; presets to 1 so csb/clk look idle after reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= filt;
    end
  end

  generate
    if (FILTER) begin : g_filt
      logic [1:0] hist_q;
      // Keep the two previous synchronised samples for the majority vote.
      always_ff @(posedge clock) begin
        if (!resetn) hist_q <= '1;
        else         hist_q <= {hist_q[0], sync_q[STAGES-1]};
      end
      assign filt = maj3(sync_q[STAGES-1], hist_q[0], hist_q[1]);
    end else begin : g_raw
      assign filt = sync_q[STAGES-1];
    end
  endgenerate

  assign level_o = filt;
  assign rise_o  = filt & ~prev_q;
  assign fall_o  = ~filt & prev_q;

endmodule

// File: rtl/marlann_qpi_phy.sv
// marlann_qpi_phy: QPI slave PHY. Oversamples host clock/csb/io in the
// system clock domain, assembles high-nibble-first bytes for the decoder and
// serialises response bytes after a one-byte turnaround.
// Build option: MARLANN_QPI_DEGLITCH_EN adds a majority filter on qpi_clk
// (one extra clock of latency, io delayed to match).
//
// state   | meaning
// RX_IDLE | csb inactive, waiting for csb fall
// RX      | host drives io, bytes assembled into rx_data
// TURN    | wait byte: 1st rise enables output, 2nd rise loads first tx byte
// TX      | PHY drives io, one nibble per host clock rise
module marlann_qpi_phy
  import marlann_qpi_phy_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic             clock,
  input  logic             resetn,
  marlann_qpi_phy_if.slave bus
);

`ifdef MARLANN_QPI_DEGLITCH_EN
  localparam bit DEGLITCH = 1'b1;
`else
  localparam bit DEGLITCH = 1'b0;
`endif
  localparam int IO_STAGES = SYNC_STAGES + int'(DEGLITCH);

  logic       clk_rise, clk_level_unused, clk_fall_unused;
  logic       csb_level, csb_rise, csb_fall;
  logic       rise_v;
  logic [3:0] io_s;
  logic [7:0] tx_byte;

  logic [IO_STAGES-1:0][3:0] io_q;

  logic [1:0] state_q, state_d;
  logic       phase_q, phase_d;
  logic [3:0] hi_q, hi_d;
  logic [3:0] lo_q, lo_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       done_q, done_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_start_q, rx_start_d;
  logic       rx_stop_q, rx_stop_d;
  logic       tx_ready_q, tx_ready_d;
  logic [3:0] io_out_q, io_out_d;
  logic       oe_q, oe_d;

  marlann_qpi_phy_sync #(.STAGES(SYNC_STAGES), .FILTER(DEGLITCH)) u_sync_clk (
    .clock(clock), .resetn(resetn), .async_i(bus.qpi_clk),
    .level_o(clk_level_unused), .rise_o(clk_rise), .fall_o(clk_fall_unused)
  );

  marlann_qpi_phy_sync #(.STAGES(SYNC_STAGES), .FILTER(1'b0)) u_sync_csb (
    .clock(clock), .resetn(resetn), .async_i(bus.qpi_csb),
    .level_o(csb_level), .rise_o(csb_rise), .fall_o(csb_fall)
  );

  // Delay io by the same depth as qpi_clk so the nibble lines up with rise.
  always_ff @(posedge clock) begin
    if (!resetn) io_q <= '1;
    else         io_q <= {io_q[IO_STAGES-2:0], bus.qpi_io_in};
  end

  assign io_s    = io_q[IO_STAGES-1];
  assign rise_v  = clk_rise & ~csb_level;
  assign tx_byte = bus.tx_valid ? bus.tx_data : IDLE_BYTE;

  // Next-state logic; a csb rise overrides everything, including a coincident clock rise.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rx_data_d  = rx_data_q;
    io_out_d   = io_out_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    rx_valid_d = done_q;
    rx_start_d = 1'b0;
    rx_stop_d  = 1'b0;
    tx_ready_d = 1'b0;
    if (csb_rise) begin
      rx_stop_d = 1'b1;
      oe_d      = 1'b0;
      phase_d   = 1'b0;
      state_d   = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (csb_fall) begin
            rx_start_d = 1'b1;
            phase_d    = 1'b0;
            state_d    = RX;
          end
        end
        RX: begin
          if (rise_v) begin
            if (!phase_q) begin
              hi_d    = io_s;
              phase_d = 1'b1;
            end else begin
              rx_data_d = {hi_q, io_s};
              done_d    = 1'b1;
              phase_d   = 1'b0;
              if (bus.tx_en) state_d = TURN;
            end
          end
        end
        TURN: begin
          if (rise_v) begin
            if (!phase_q) begin
              oe_d    = 1'b1;
              phase_d = 1'b1;
            end else begin
              io_out_d   = tx_byte[7:4];
              lo_d       = tx_byte[3:0];
              tx_ready_d = bus.tx_valid;
              phase_d    = 1'b1;
              state_d    = TX;
            end
          end
        end
        default: begin
          if (rise_v) begin
            if (phase_q) begin
              io_out_d = lo_q;
              phase_d  = 1'b0;
            end else begin
              io_out_d   = tx_byte[7:4];
              lo_d       = tx_byte[3:0];
              tx_ready_d = bus.tx_valid;
              phase_d    = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= RX_IDLE;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_start_q <= 1'b0;
      rx_stop_q  <= 1'b0;
      tx_ready_q <= 1'b0;
      io_out_q   <= '0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      rx_start_q <= rx_start_d;
      rx_stop_q  <= rx_stop_d;
      tx_ready_q <= tx_ready_d;
      io_out_q   <= io_out_d;
      oe_q       <= oe_d;
    end
  end

  assign bus.qpi_io_out = io_out_q;
  assign bus.qpi_io_oe  = oe_q & ~bus.qpi_csb;
  assign bus.rx_start   = rx_start_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_stop    = rx_stop_q;
  assign bus.tx_ready   = tx_ready_q;

endmodule
